// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, with a stalling memory handshake and illegal-opcode trap.
module rv_multicycle_ctrl #(
    parameter int INSTRET_W = 32,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [1:0]           imm_src,
    output logic                 illegal,
    output logic                 mem_timeout,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t                state_q, state_d;
    logic [INSTRET_W-1:0]  instret_q;
    logic                  illegal_q;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    logic       mem_req_s, mem_write_s, ir_write_s, reg_write_s;
    logic       pc_update_s, branch_s, retire_s, taken_s, timeout_s;
    logic       adr_src_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;
    logic       unused_funct7b5_s;

    assign unused_funct7b5_s = funct7b5;

    // Only beq/bne resolve here; the remaining branch encodings never redirect the PC.
    assign taken_s = (funct3[2:1] == 2'b00) & (zero ^ funct3[0]);

    // Next-state and per-state control decode.
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        retire_s     = 1'b0;
        adr_src_s    = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (mem_ready) begin
                    ir_write_s  = 1'b1;
                    pc_update_s = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode)
                    7'b0000011: state_d = S_MEMADR;
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (opcode[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly so decode can use it early.
    always_comb begin
        case (opcode)
            7'b0000011: imm_src = 2'b00;
            7'b0010011: imm_src = 2'b00;
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // Memory wait watchdog: counts consecutive stalled requests.
    always_comb begin
        timeout_s = (MAX_WAIT != 0) && mem_req && !mem_ready && (wait_q == WAIT_LAST);
        if (!mem_req || mem_ready || timeout_s) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State, retired count, sticky trap flag and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire_s) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Reset gates every strobe in the same cycle so no partial access escapes.
    assign mem_req     = mem_req_s & ~rst;
    assign mem_write   = mem_write_s & ~rst;
    assign ir_write    = ir_write_s & ~rst;
    assign reg_write   = reg_write_s & ~rst;
    assign pc_write    = (pc_update_s | (branch_s & taken_s)) & ~rst;
    assign adr_src     = adr_src_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign alu_op      = alu_op_s;
    assign result_src  = result_src_s;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_s;
    assign instret     = instret_q;
    assign state       = state_q;

endmodule
